// File: rtl/clkmeas_pkg.sv
// ----------------------------------------------------------------------------
// clkmeas_pkg
//   Shared definitions for the clock/strobe measurement block.
//   - clkmeas_state_t : measurement FSM states
//   - SYNC_MIN_STAGES : smallest synchronizer depth that is allowed
// ----------------------------------------------------------------------------
package clkmeas_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_FIRST = 2'd1,
        MEASURE    = 2'd2
    } clkmeas_state_t;

    localparam int unsigned SYNC_MIN_STAGES = 2;

endpackage

// File: rtl/clkmeas_sync.sv
// ----------------------------------------------------------------------------
// sync_ff
//   Generic N-stage single-bit synchronizer for an asynchronous input.
//   Ports:
//     clk  : destination clock, all flops on posedge
//     rst_ : asynchronous active-low reset, clears every stage to 0
//     d    : asynchronous input
//     q    : synchronized output (last stage)
// ----------------------------------------------------------------------------
module sync_ff
    import clkmeas_pkg::*;
#(
    parameter int unsigned STAGES = SYNC_MIN_STAGES
) (
    input  logic clk,
    input  logic rst_,
    input  logic d,
    output logic q
);

    if (STAGES < SYNC_MIN_STAGES) begin : g_bad_stages
        $error("sync_ff: STAGES must be at least %0d", SYNC_MIN_STAGES);
    end

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/clkmeas.sv
// ----------------------------------------------------------------------------
// clkmeas
//   Measures a slow, possibly asynchronous periodic signal in units of clk.
//   The input is synchronized, each synchronized rising edge produces a
//   one-cycle rise pulse, and every complete cycle between two rise pulses
//   reports its period and the number of cycles the signal was high.
//   A missing edge for TIMEOUT cycles flags the signal as lost.
//   Ports:
//     clk    : system clock, all logic on posedge
//     rst_   : asynchronous active-low reset
//     ena    : measurement enable, low forces IDLE
//     sig    : asynchronous signal under measurement
//     rise   : one-cycle pulse per synchronized rising edge of sig
//     period : clk cycles between the last two rise pulses
//     high   : cycles the synchronized sig was high within that window
//     valid  : one-cycle pulse when period/high update
//     locked : a full period was measured and no timeout since
//     lost   : sticky timeout flag
// ----------------------------------------------------------------------------
module clkmeas
    import clkmeas_pkg::*;
#(
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT     = 'd100000000
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             ena,
    input  logic             sig,
    output logic             rise,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high,
    output logic             valid,
    output logic             locked,
    output logic             lost
);

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    if (SYNC_STAGES < SYNC_MIN_STAGES) begin : g_bad_sync
        $error("clkmeas: SYNC_STAGES must be at least %0d", SYNC_MIN_STAGES);
    end

    if (TIMEOUT == 0 || (TIMEOUT >> CNT_W) != 0) begin : g_bad_timeout
        $error("clkmeas: TIMEOUT must be nonzero and below 2**CNT_W");
    end

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    // ------------------------------------------------------------------
    // Input synchronizer and edge detect
    // ------------------------------------------------------------------
    logic s_q;
    logic s_d;

    sync_ff #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .rst_ (rst_),
        .d    (sig),
        .q    (s_q)
    );

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            s_d  <= 1'b0;
            rise <= 1'b0;
        end else begin
            s_d  <= s_q;
            rise <= s_q & ~s_d & ena;
        end
    end

    // ------------------------------------------------------------------
    // Measurement FSM
    // ------------------------------------------------------------------
    clkmeas_state_t state;
    clkmeas_state_t state_nxt;

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] hcnt;

    logic at_timeout;
    logic arm;      // first rise after (re)arming: start counting, no report
    logic meas;     // rise closing a complete period: report it
    logic tmo;      // no rise for TIMEOUT cycles

    assign at_timeout = (cnt == TIMEOUT_C);

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A rise in the same cycle as the timeout wins: it is checked first.
    always_comb begin
        state_nxt = state;
        arm       = 1'b0;
        meas      = 1'b0;
        tmo       = 1'b0;
        if (!ena) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = WAIT_FIRST;
                end
                WAIT_FIRST: begin
                    if (rise) begin
                        arm       = 1'b1;
                        state_nxt = MEASURE;
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        meas = 1'b1;
                    end else if (at_timeout) begin
                        tmo       = 1'b1;
                        state_nxt = WAIT_FIRST;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Period and high-time counters
    // The rise cycle itself is the first cycle of the new window, so the
    // counters load 1 / s_q rather than clearing.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            cnt  <= '0;
            hcnt <= '0;
        end else if (arm || meas) begin
            cnt  <= CNT_W'(1);
            hcnt <= CNT_W'(s_q);
        end else if (state == MEASURE && state_nxt == MEASURE) begin
            if (cnt != '1) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (s_q && hcnt != '1) begin
                hcnt <= hcnt + CNT_W'(1);
            end
        end else begin
            cnt  <= '0;
            hcnt <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Result registers and status flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            period <= '0;
            high   <= '0;
            valid  <= 1'b0;
        end else begin
            valid <= meas;
            if (meas) begin
                period <= cnt;
                high   <= hcnt;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            locked <= 1'b0;
            lost   <= 1'b0;
        end else if (!ena) begin
            locked <= 1'b0;
            lost   <= 1'b0;
        end else if (meas) begin
            locked <= 1'b1;
            lost   <= 1'b0;
        end else if (tmo) begin
            locked <= 1'b0;
            lost   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_clkmeas.sv
// ----------------------------------------------------------------------------
// tb_clkmeas
//   Self-checking bench for clkmeas (CNT_W=16, SYNC_STAGES=2, TIMEOUT=64).
//   A reference model works from the history of sig/ena values per cycle and
//   the arithmetic definitions of period/high; expected measurements go into
//   a scoreboard queue that a monitor drains whenever valid is seen.
// ----------------------------------------------------------------------------
module tb_clkmeas;

    localparam int unsigned W   = 16;
    localparam int unsigned NS  = 2;
    localparam int          TMO = 64;

    logic         clk = 1'b0;
    logic         rst_;
    logic         ena;
    logic         sig;
    logic         rise;
    logic [W-1:0] period;
    logic [W-1:0] high;
    logic         valid;
    logic         locked;
    logic         lost;

    clkmeas #(
        .CNT_W       (W),
        .SYNC_STAGES (NS),
        .TIMEOUT     (TMO)
    ) dut (
        .clk    (clk),
        .rst_   (rst_),
        .ena    (ena),
        .sig    (sig),
        .rise   (rise),
        .period (period),
        .high   (high),
        .valid  (valid),
        .locked (locked),
        .lost   (lost)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model + scoreboard monitor
    // sh holds the value of sig during each past cycle (0 while in reset).
    // ------------------------------------------------------------------
    typedef struct {
        int          cyc;
        int unsigned p;
        int unsigned h;
    } exp_t;

    exp_t        sb[$];
    bit          sh[$];
    bit          exp_rise;
    bit          m_locked;
    bit          m_lost;
    bit          have_ref;
    int unsigned m_period;
    int unsigned m_high;
    int unsigned hsum;
    int          ref_cyc;

    initial begin
        for (int i = 0; i < 16; i++) sh.push_back(1'b0);
        exp_rise = 0; m_locked = 0; m_lost = 0; have_ref = 0;
        m_period = 0; m_high = 0; hsum = 0; ref_cyc = 0;
    end

    always @(negedge clk) begin
        bit   sq;
        bit   sd;
        exp_t e;
        if (!rst_) begin
            sh.push_back(1'b0);
            exp_rise = 0; m_locked = 0; m_lost = 0; have_ref = 0;
            m_period = 0; m_high = 0; hsum = 0;
            sb.delete();
        end else begin
            chk("rise", rise, exp_rise);
            chk("locked", locked, m_locked);
            chk("lost", lost, m_lost);
            chk("period_hold", period, m_period);
            chk("high_hold", high, m_high);
            if (valid) begin
                if (sb.size() == 0) begin
                    chk("valid_unexpected", valid, 1'b0);
                end else begin
                    e = sb.pop_front();
                    chk("valid_cycle", cyc, e.cyc);
                    chk("valid_period", period, e.p);
                    chk("valid_high", high, e.h);
                end
            end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                chk("valid_missing", valid, 1'b1);
            end

            // Advance the model by this cycle.
            sh.push_back(sig);
            sq = sh[sh.size() - 1 - NS];
            sd = sh[sh.size() - 2 - NS];
            if (!ena) begin
                have_ref = 0; m_locked = 0; m_lost = 0;
            end else if (exp_rise) begin
                if (have_ref) begin
                    e.cyc = cyc + 1;
                    e.p   = cyc - ref_cyc;
                    e.h   = hsum;
                    sb.push_back(e);
                    m_period = e.p; m_high = e.h;
                    m_locked = 1;   m_lost = 0;
                end
                have_ref = 1; ref_cyc = cyc; hsum = sq;
            end else if (have_ref) begin
                if (cyc - ref_cyc == TMO) begin
                    have_ref = 0; m_lost = 1; m_locked = 0;
                end else begin
                    hsum += sq;
                end
            end
            exp_rise = sq & ~sd & ena;
        end
        if (sh.size() > 16) void'(sh.pop_front());
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic step(input bit s);
        @(posedge clk);
        #1;
        sig = s;
    endtask

    task automatic wave(input int p, input int h, input int n);
        for (int k = 0; k < n; k++)
            for (int i = 0; i < p; i++)
                step(i < h);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_rise"},   rise,   0);
        chk({tag, "_valid"},  valid,  0);
        chk({tag, "_locked"}, locked, 0);
        chk({tag, "_lost"},   lost,   0);
        chk({tag, "_period"}, period, 0);
        chk({tag, "_high"},   high,   0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ = 1'b0;
        ena  = 1'b0;
        sig  = 1'b0;

        // Reset held while sig toggles
        for (int i = 0; i < 8; i++) begin
            step(i[0]);
            chk_zero("rst");
        end
        @(posedge clk); #1; rst_ = 1'b1;

        // Released with ena low: model expects no rise/valid
        for (int i = 0; i < 30; i++) step(i % 3 == 0);

        // Regular 10/6 input
        ena = 1'b1;
        wave(10, 6, 8);
        chk("reg_locked", locked, 1);
        chk("reg_period", period, 10);
        chk("reg_high", high, 6);

        // Timeout after holding sig low
        for (int i = 0; i < 100; i++) step(0);
        chk("tmo_lost", lost, 1);
        chk("tmo_locked", locked, 0);
        chk("tmo_period", period, 10);

        // Isolated edge latency: sampled on edge 1, rise after edge 3
        step(1);
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk); #1;
            chk($sformatf("lat_rise_e%0d", i), rise, (i == 3));
        end

        // Resume toggling: lost clears once a full period is measured
        wave(10, 6, 4);
        chk("resume_lost", lost, 0);
        chk("resume_locked", locked, 1);

        // Rise coincident with cnt == TIMEOUT
        wave(64, 20, 4);
        chk("bnd_period", period, 64);
        chk("bnd_high", high, 20);
        chk("bnd_lost", lost, 0);

        // Drop ena mid-period
        wave(10, 6, 3);
        for (int i = 0; i < 4; i++) step(1);
        ena = 1'b0;
        @(posedge clk); #1;
        chk("ena_locked", locked, 0);
        chk("ena_valid", valid, 0);
        chk("ena_period", period, 10);
        for (int i = 0; i < 5; i++) step(0);
        ena = 1'b1;
        wave(10, 6, 4);

        // Asynchronous reset in the middle of a high phase
        wave(10, 6, 3);
        step(1);
        step(1);
        #2;
        rst_ = 1'b0;
        #1;
        chk_zero("arst");
        repeat (3) @(posedge clk);
        #1;
        rst_ = 1'b1;
        wave(10, 6, 4);
        chk("arst_relock", locked, 1);
        chk("arst_period", period, 10);

        // Randomized periods, duty cycles and enable drops
        for (int s = 0; s < 40; s++) begin
            int p;
            int h;
            int n;
            p = $urandom_range(80, 2);
            h = $urandom_range(p - 1, 1);
            n = $urandom_range(4, 1);
            wave(p, h, n);
            if ($urandom_range(7, 0) == 0) begin
                ena = 1'b0;
                n = $urandom_range(5, 1);
                for (int i = 0; i < n; i++) step(sig);
                ena = 1'b1;
            end
        end

        for (int i = 0; i < 5; i++) step(0);
        chk("sb_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/clkmeas.md
Name: clkmeas

Overview:
- Receiving end of a divided clock-enable: measures a slow, possibly asynchronous periodic signal in units of the fast system clock.
- Synchronizes the input, emits a one-cycle tick per rising edge, and reports period and high time per complete cycle.
- Flags loss of the signal on timeout.
- Used in UTILS to check divider outputs and to recover strobes from external slow clocks.

Parameters:
- CNT_W, 32: width of the period/high counters and outputs.
- SYNC_STAGES, 2: synchronizer depth, minimum 2.
- TIMEOUT, 'd100000000: clk cycles without a rising edge before the signal is declared lost. Must be < 2**CNT_W (elaboration-time check).

Ports:
- clk, input, 1: system clock, all logic on posedge.
- rst_, input, 1: reset, asynchronous and active-low.
- ena, input, 1: measurement enable. Low forces IDLE.
- sig, input, 1: asynchronous signal under measurement.
- rise, output, 1: one-cycle pulse per synchronized rising edge of sig.
- period, output, CNT_W: clk cycles between the last two rise pulses.
- high, output, CNT_W: cycles the synchronized sig was high within that window.
- valid, output, 1: one-cycle pulse when period/high update.
- locked, output, 1: at least one complete period measured and no timeout since.
- lost, output, 1: sticky timeout flag.

Behaviour:
- Reset (rst_ low, any time, asynchronous): all flops 0. FSM goes to IDLE. Outputs rise=0, period=0, high=0, valid=0, locked=0, lost=0.
- Synchronizer:
  - SYNC_STAGES flops on sig, reset to 0. Last stage is s_q.
  - s_d is s_q delayed one cycle.
  - rise is registered: rise <= s_q & ~s_d & ena. First rise pulse appears SYNC_STAGES+1 edges after the first edge sampling sig high.
- Counter cnt:
  - In MEASURE, increments every cycle.
  - On a rise pulse, loads 1.
  - Counter hcnt increments in cycles where s_q=1 and loads s_q on rise.
- FSM states: IDLE, WAIT_FIRST, MEASURE.
  - IDLE: cnt=hcnt=0, locked=0, lost=0. Goes to WAIT_FIRST when ena=1.
  - WAIT_FIRST: counters cleared. On rise, goes to MEASURE (no valid).
  - MEASURE, on rise: period<=cnt, high<=hcnt, valid=1 next cycle, locked<=1, lost<=0, counters restart. Stays in MEASURE.
  - MEASURE, when cnt reaches TIMEOUT with no rise: lost<=1, locked<=0, go to WAIT_FIRST. period/high hold their values.
- Arithmetic and timing definitions:
  - period equals b-a for consecutive rise pulses at cycles a and b.
  - high counts cycles in [a, b) where s_q=1.
  - Counters never wrap. Guaranteed by TIMEOUT < 2**CNT_W; additionally saturate at all-ones.
- Simultaneous events:
  - Rise in the same cycle cnt reaches TIMEOUT: rise wins, so a measurement occurs and no lost.
  - ena falling in any state: IDLE next cycle. valid and rise are suppressed, locked and lost clear. period/high hold last values.
- A rise with ena=0 is ignored. After ena returns, the first edge only arms the counters (WAIT_FIRST).
- lost stays asserted until the next valid measurement, ena low, or reset.

Decomposition:
- Shared utils package holds the FSM state enum (clkmeas_state_t: IDLE, WAIT_FIRST, MEASURE) and the minimum-sync-stages constant.
- Sub-module sync_ff (generic N-stage synchronizer, async active-low reset, clk/rst_ ports) instantiated once for sig.
- Counters stay inline.

Test Plan:
- Reset/idle: rst_ low with sig toggling → all outputs 0. Release with ena=0 → rise/valid remain 0.
- Regular input: ena=1, sig period 10 cycles, high 6 (splitter-like) → no valid on first rise. From second rise on: valid every 10 cycles with period=10, high=6, and locked=1.
- Latency: single isolated sig edge, SYNC_STAGES=2 → rise pulse on the 3rd clk edge after sampling, exactly one cycle wide.
- Timeout: TIMEOUT=64, lock on period 10, then hold sig low → lost=1 and locked=0 exactly 64 cycles after the last rise, period stays 10. Resume toggling → lost clears on the second new rise.
- Boundary: rise coincident with cnt==TIMEOUT (period 64, TIMEOUT=64) → valid with period=64, lost stays 0.
- Mid-operation disruption: drop ena mid-period → next cycle locked=0, no valid, period holds. Assert rst_ asynchronously mid-high-phase → outputs 0 immediately, remeasurement needs two rises.
